px_bounce_gen: RTL
==================

# px_bounce_gen

Pixel source for `vga_controller`, one stage upstream of it. For each `px_h`/`px_v` coordinate the controller publishes, it returns `px_data` one `px_clk` later. The picture is a four-quadrant grey background with a solid square that moves by a fixed step once per frame and bounces off the active-area edges. It replaces the bench-side colour task with synthesizable logic and gives the display path a frame-rate-visible motion test.

## Interface
- `H_ACTIVE`, 640: active pixels per line.
- `V_ACTIVE`, 480: active lines per frame.
- `BOX_SIZE`, 32: square edge length in pixels. Constraint: `BOX_SIZE + STEP <= min(H_ACTIVE, V_ACTIVE)`.
- `STEP`, 4: pixels moved per frame on each axis. Must be at least 1.
- `BOX_COLOR`, 12'hF00: box colour (RGB 4:4:4) after reset.
- `px_clk`  in  1  pixel clock. All state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pause`  in  1  when high, freezes box motion. Sampled at frame update.
- `px_h`  in  11  horizontal coordinate from `vga_controller`.
- `px_v`  in  11  vertical coordinate from `vga_controller`.
- `px_data`  out  12  registered pixel colour {R[3:0],G[3:0],B[3:0]} to `vga_controller`.
- `frame_tick`  out  1  one-cycle pulse, once per frame, after each update point.

## Operation
- **Reset values**
  - `px_data` = 12'h000, `frame_tick` = 0.
  - Box position `bx` = 0, `by` = 0.
  - Direction state = DOWN_RIGHT.
  - Box colour = `BOX_COLOR`.
  - The reset is synchronous: `rst` is honoured at a clock edge, including mid-frame. The next edge after `rst` deasserts resumes normal operation.
- **Pixel path, evaluated each cycle**
  - A pixel is inside the box if `bx <= px_h < bx+BOX_SIZE` and `by <= px_v < by+BOX_SIZE`.
  - Inside box: output the box colour.
  - Else if `px_h >= H_ACTIVE` or `px_v >= V_ACTIVE`: output 12'h000.
  - Else the background quadrants apply, split at `H_ACTIVE/2` and `V_ACTIVE/2`:
    - top-left: 12'hAAA
    - top-right: 12'hBBB
    - bottom-left: 12'hCCC
    - bottom-right: 12'hDDD
  - All compares are done at 12-bit width so that `bx+BOX_SIZE` cannot overflow.
- **Frame update point**
  - `vblank` = (`px_v >= V_ACTIVE`), registered as `vblank_q`.
  - The update point is the cycle in which `vblank` = 1 and `vblank_q` = 0 (rising edge), i.e. exactly once per frame.
  - Repeated or held coordinates do not retrigger it.
- **Direction FSM**
  - States: DOWN_RIGHT, DOWN_LEFT, UP_RIGHT, UP_LEFT, encoded as {dy, dx} with 1 meaning +.
  - State changes only at an update point with `pause` = 0.
- **Horizontal update (vertical is symmetric with `by`, `V_ACTIVE`, dy)**
  - dx = +:
    - if `bx + STEP >= H_ACTIVE - BOX_SIZE`: `bx` = `H_ACTIVE - BOX_SIZE`, dx becomes −, flag hit.
    - else `bx` += `STEP`.
  - dx = −:
    - if `bx <= STEP`: `bx` = 0, dx becomes +, flag hit.
    - else `bx` −= `STEP`.
  - Position is clamped to the wall, never overshoots.
  - A simultaneous horizontal and vertical hit (corner) flips both directions in the same update and counts as one hit event.
- **Pause**
  - With `pause` = 1 at the update point, `bx`, `by`, direction and colour hold.
  - `frame_tick` still pulses.

## Timing
- Pixel latency is exactly 1 cycle: `px_data` at edge n+1 reflects `px_h`/`px_v` sampled at edge n.
- At the update point edge, `bx`, `by` and the FSM update. `frame_tick` is high for the following cycle only.
- The box moves during blanking. Every active pixel of a frame therefore uses one consistent position.
- The first update after reset gives `bx` = `by` = `STEP`.

## Configuration
- `BOUNCE_COLOR_CYCLE_EN` defined:
  - Each hit event adds 12'h111 to the box colour, wrapping modulo 2^12 (12'hFFF + 12'h111 = 12'h110).
  - A corner hit adds once.
  - Reset restores `BOX_COLOR`.
- Not defined: the box colour is constant `BOX_COLOR` and no colour register exists.

## Test plan
- **Reset and background:** assert `rst` mid-frame, release, scan full frame. `px_data` = 12'h000 during reset. (10,10) → 12'hF00 (box). (400,10) → 12'hBBB, (10,300) → 12'hCCC, (400,300) → 12'hDDD, (700,10) → 12'h000. Each value appears one cycle after the coordinate.
- **Motion:** default params, one full frame after reset. `frame_tick` pulses once as `px_v` goes 479 → 480. Next frame: (4,4) is box, (3,4) is 12'hAAA, (36,4) is 12'hAAA.
- **Right wall clamp:** run 150 frames from reset. `bx` sequence …600, 604, 608, then 604. Left edge is never > 608, right edge is never > 639.
- **Corner bounce:** H_ACTIVE = V_ACTIVE = 64, BOX_SIZE = 32, STEP = 4. After 8 frames `bx` = `by` = 32 and state is UP_LEFT. Next frame gives 28,28. With `BOUNCE_COLOR_CYCLE_EN`, colour becomes 12'h011 (one increment).
- **Pause:** hold `pause` = 1 across 5 update points. `frame_tick` pulses 5 times and position and colour are unchanged. Release: the next update moves by `STEP`.
- **Held coordinates:** hold `px_v` = 480 for 1000 cycles. Exactly one `frame_tick` and one position update.

Source files
------------

// File: rtl/px_bounce_gen.sv
// px_bounce_gen: pixel source one stage upstream of vga_controller.
// Draws a four-quadrant grey background with a solid square that moves
// once per frame (during vertical blanking) and bounces off the edges.
// Optional feature macro: BOUNCE_COLOR_CYCLE_EN (box colour steps by
// 12'h111 on every wall hit).
module px_bounce_gen #(
    parameter int          H_ACTIVE  = 640,
    parameter int          V_ACTIVE  = 480,
    parameter int          BOX_SIZE  = 32,
    parameter int          STEP      = 4,
    parameter logic [11:0] BOX_COLOR = 12'hF00
) (
    input  logic        px_clk,
    input  logic        rst,
    input  logic        pause,
    input  logic [10:0] px_h,
    input  logic [10:0] px_v,
    output logic [11:0] px_data,
    output logic        frame_tick
);

    localparam logic [11:0] H_ACT_W = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT_W = 12'(V_ACTIVE);
    localparam logic [11:0] BOX_W   = 12'(BOX_SIZE);
    localparam logic [11:0] STEP_W  = 12'(STEP);
    localparam logic [11:0] H_LIM   = 12'(H_ACTIVE - BOX_SIZE);
    localparam logic [11:0] V_LIM   = 12'(V_ACTIVE - BOX_SIZE);
    localparam logic [11:0] H_HALF  = 12'(H_ACTIVE / 2);
    localparam logic [11:0] V_HALF  = 12'(V_ACTIVE / 2);

    // Direction encoded as {dy, dx}, a 1 meaning the positive direction.
    typedef enum logic [1:0] {
        UP_LEFT    = 2'b00,
        UP_RIGHT   = 2'b01,
        DOWN_LEFT  = 2'b10,
        DOWN_RIGHT = 2'b11
    } dir_t;

    dir_t        dir_q;
    dir_t        dir_next;
    logic [11:0] bx_q;
    logic [11:0] by_q;
    logic [11:0] bx_next;
    logic [11:0] by_next;
    logic        hit_h;
    logic        hit_v;
    logic        vblank;
    logic        vblank_q;
    logic        update;
    logic [11:0] h_w;
    logic [11:0] v_w;
    logic        in_box;
    logic [11:0] pix_next;
    logic [11:0] box_color;

    assign h_w    = {1'b0, px_h};
    assign v_w    = {1'b0, px_v};
    assign vblank = (v_w >= V_ACT_W);
    assign update = vblank && !vblank_q;

`ifdef BOUNCE_COLOR_CYCLE_EN
    logic hit;
    assign hit = hit_h | hit_v;

    // Box colour advances once per hit event; a corner hit counts once.
    always_ff @(posedge px_clk) begin
        if (rst) begin
            box_color <= BOX_COLOR;
        end else if (hit) begin
            box_color <= box_color + 12'h111;
        end
    end
`else
    assign box_color = BOX_COLOR;
`endif

    // Next position and direction, only moving at an unpaused update point.
    always_comb begin
        bx_next  = bx_q;
        by_next  = by_q;
        dir_next = dir_q;
        hit_h    = 1'b0;
        hit_v    = 1'b0;
        if (update && !pause) begin
            if (dir_q[0]) begin
                if (bx_q + STEP_W >= H_LIM) begin
                    bx_next = H_LIM;
                    hit_h   = 1'b1;
                end else begin
                    bx_next = bx_q + STEP_W;
                end
            end else begin
                if (bx_q <= STEP_W) begin
                    bx_next = 12'd0;
                    hit_h   = 1'b1;
                end else begin
                    bx_next = bx_q - STEP_W;
                end
            end
            if (dir_q[1]) begin
                if (by_q + STEP_W >= V_LIM) begin
                    by_next = V_LIM;
                    hit_v   = 1'b1;
                end else begin
                    by_next = by_q + STEP_W;
                end
            end else begin
                if (by_q <= STEP_W) begin
                    by_next = 12'd0;
                    hit_v   = 1'b1;
                end else begin
                    by_next = by_q - STEP_W;
                end
            end
            dir_next = dir_t'({dir_q[1] ^ hit_v, dir_q[0] ^ hit_h});
        end
    end

    // Position, direction and blanking-edge state; vblank_q resets high so
    // releasing reset inside blanking does not fire a spurious update.
    always_ff @(posedge px_clk) begin
        if (rst) begin
            bx_q       <= 12'd0;
            by_q       <= 12'd0;
            dir_q      <= DOWN_RIGHT;
            vblank_q   <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            bx_q       <= bx_next;
            by_q       <= by_next;
            dir_q      <= dir_next;
            vblank_q   <= vblank;
            frame_tick <= update;
        end
    end

    // Colour for the current coordinate: box, then blanking, then quadrant.
    always_comb begin
        in_box = (h_w >= bx_q) && (h_w < bx_q + BOX_W) &&
                 (v_w >= by_q) && (v_w < by_q + BOX_W);
        if (in_box) begin
            pix_next = box_color;
        end else if ((h_w >= H_ACT_W) || (v_w >= V_ACT_W)) begin
            pix_next = 12'h000;
        end else if (v_w < V_HALF) begin
            pix_next = (h_w < H_HALF) ? 12'hAAA : 12'hBBB;
        end else begin
            pix_next = (h_w < H_HALF) ? 12'hCCC : 12'hDDD;
        end
    end

    // Registered pixel output gives exactly one cycle of latency.
    always_ff @(posedge px_clk) begin
        if (rst) begin
            px_data <= 12'h000;
        end else begin
            px_data <= pix_next;
        end
    end

endmodule
